mult_pipe: RTL and testbench

MULT_PIPE -- requirements
Module: mult_pipe

---
 rtl/mult_pipe_pkg.sv | 16 +
 rtl/mult_pipe_if.sv | 35 +++
 rtl/mult_pipe_stage.sv | 96 +++++++++
 rtl/mult_pipe.sv | 85 ++++++++
 tb/tb_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared constants for the pipelined unsigned multiplier: default geometry
// and the encoding of the product-half select.
package mult_pipe_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;
    localparam int DEF_DEST_W = 5;
    localparam int DEF_NPC_W  = 64;

    // hi_sel encoding: MULQ returns the low half, UMULH the high half.
    typedef enum logic {
        SEL_MULQ  = 1'b0,
        SEL_UMULH = 1'b1
    } hi_sel_e;

endpackage

// File: rtl/mult_pipe_if.sv
// Issue/result bundle of the multiplier pipe. The master side issues
// operations and consumes results; the slave side is the pipe itself.
interface mult_pipe_if
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEST_W = DEF_DEST_W,
    parameter int NPC_W  = DEF_NPC_W
);

    logic              valid_in;
    logic              ready_out;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  mcand;
    logic              hi_sel;
    logic [DEST_W-1:0] dest_reg_in;
    logic [NPC_W-1:0]  npc_in;
    logic              flush;
    logic              stall;
    logic              valid_out;
    logic [WIDTH-1:0]  product;
    logic [DEST_W-1:0] dest_reg_out;
    logic [NPC_W-1:0]  npc_out;

    modport master (
        output valid_in, mplier, mcand, hi_sel, dest_reg_in, npc_in, flush, stall,
        input  ready_out, valid_out, product, dest_reg_out, npc_out
    );

    modport slave (
        input  valid_in, mplier, mcand, hi_sel, dest_reg_in, npc_in, flush, stall,
        output ready_out, valid_out, product, dest_reg_out, npc_out
    );

endinterface

// File: rtl/mult_pipe_stage.sv
// One multiplier stage: folds CHUNK multiplier bits into the running
// 2*WIDTH partial sum, then shifts the operands for the next stage.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEST_W = DEF_DEST_W,
    parameter int NPC_W  = DEF_NPC_W,
    parameter int CHUNK  = DEF_WIDTH / DEF_STAGES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               vld_i,
    input  logic               hi_sel_i,
    input  logic [DEST_W-1:0]  dest_i,
    input  logic [NPC_W-1:0]   npc_i,
    input  logic [2*WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0]   mplier_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    output logic               vld_o,
    output logic               hi_sel_o,
    output logic [DEST_W-1:0]  dest_o,
    output logic [NPC_W-1:0]   npc_o,
    output logic [2*WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0]   mplier_o,
    output logic [2*WIDTH-1:0] mcand_o
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]     pp;
    logic              vld_q,    vld_d;
    logic              hi_sel_q, hi_sel_d;
    logic [DEST_W-1:0] dest_q,   dest_d;
    logic [NPC_W-1:0]  npc_q,    npc_d;
    logic [PW-1:0]     sum_q,    sum_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     mcand_q,  mcand_d;

    // Partial product and next state; the stage holds unless told to load,
    // and a flush empties it regardless of what is being loaded.
    always_comb begin
        pp       = {{(PW-CHUNK){1'b0}}, mplier_i[CHUNK-1:0]} * mcand_i;
        vld_d    = vld_q;
        hi_sel_d = hi_sel_q;
        dest_d   = dest_q;
        npc_d    = npc_q;
        sum_d    = sum_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        if (load_i) begin
            vld_d    = vld_i;
            hi_sel_d = hi_sel_i;
            dest_d   = dest_i;
            npc_d    = npc_i;
            sum_d    = sum_i + pp;
            mplier_d = mplier_i >> CHUNK;
            mcand_d  = mcand_i << CHUNK;
        end
        if (flush_i) begin
            vld_d = 1'b0;
        end
    end

    // Stage registers; reset clears data too so the pipe output reads zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q    <= 1'b0;
            hi_sel_q <= 1'b0;
            dest_q   <= '0;
            npc_q    <= '0;
            sum_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            hi_sel_q <= hi_sel_d;
            dest_q   <= dest_d;
            npc_q    <= npc_d;
            sum_q    <= sum_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
        end
    end

    assign vld_o    = vld_q;
    assign hi_sel_o = hi_sel_q;
    assign dest_o   = dest_q;
    assign npc_o    = npc_q;
    assign sum_o    = sum_q;
    assign mplier_o = mplier_q;
    assign mcand_o  = mcand_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier with elastic stages:
// bubbles collapse under stall, flush squashes everything in flight.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int DEST_W = DEF_DEST_W,
    parameter int NPC_W  = DEF_NPC_W
) (
    input  logic       clock,
    input  logic       reset,
    mult_pipe_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int PW    = 2 * WIDTH;

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [STAGES:0]   vld_c;
    logic [STAGES:0]   hi_c;
    logic [DEST_W-1:0] dest_c [STAGES+1];
    logic [NPC_W-1:0]  npc_c  [STAGES+1];
    logic [PW-1:0]     sum_c  [STAGES+1];
    logic [WIDTH-1:0]  mpl_c  [STAGES+1];
    logic [PW-1:0]     mcd_c  [STAGES+1];

    // room_c[k]: stage k is empty or its content moves on this cycle.
    logic [STAGES-1:0] room_c;
    logic              room_nxt;

    assign vld_c[0]  = bus.valid_in & ~bus.flush;
    assign hi_c[0]   = bus.hi_sel;
    assign dest_c[0] = bus.dest_reg_in;
    assign npc_c[0]  = bus.npc_in;
    assign sum_c[0]  = '0;
    assign mpl_c[0]  = bus.mplier;
    assign mcd_c[0]  = {{WIDTH{1'b0}}, bus.mcand};

    // Back-propagate space from the output toward the input.
    always_comb begin
        room_nxt = ~bus.stall;
        room_c   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room_c[k] = ~vld_c[k+1] | room_nxt;
            room_nxt  = room_c[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mult_pipe_stage #(
            .WIDTH  (WIDTH),
            .DEST_W (DEST_W),
            .NPC_W  (NPC_W),
            .CHUNK  (CHUNK)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush_i  (bus.flush),
            .load_i   (room_c[k]),
            .vld_i    (vld_c[k]),
            .hi_sel_i (hi_c[k]),
            .dest_i   (dest_c[k]),
            .npc_i    (npc_c[k]),
            .sum_i    (sum_c[k]),
            .mplier_i (mpl_c[k]),
            .mcand_i  (mcd_c[k]),
            .vld_o    (vld_c[k+1]),
            .hi_sel_o (hi_c[k+1]),
            .dest_o   (dest_c[k+1]),
            .npc_o    (npc_c[k+1]),
            .sum_o    (sum_c[k+1]),
            .mplier_o (mpl_c[k+1]),
            .mcand_o  (mcd_c[k+1])
        );
    end

    assign bus.ready_out    = ~bus.flush & room_c[0];
    assign bus.valid_out    = vld_c[STAGES];
    assign bus.product      = (hi_c[STAGES] == SEL_UMULH) ? sum_c[STAGES][PW-1:WIDTH]
                                                          : sum_c[STAGES][WIDTH-1:0];
    assign bus.dest_reg_out = dest_c[STAGES];
    assign bus.npc_out      = npc_c[STAGES];

endmodule

// File: tb/tb_mult_pipe.sv
// Directed + scoreboard bench for mult_pipe (64x64/4 stages and 32x32/2 stages).
module tb_mult_pipe;

    typedef struct packed {
        logic [63:0] prod;
        logic [4:0]  dest;
        logic [63:0] npc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_pipe_if #(.WIDTH(64), .DEST_W(5), .NPC_W(64)) bus ();
    mult_pipe_if #(.WIDTH(32), .DEST_W(5), .NPC_W(64)) bus32 ();

    mult_pipe #(.WIDTH(64), .STAGES(4), .DEST_W(5), .NPC_W(64)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    mult_pipe #(.WIDTH(32), .STAGES(2), .DEST_W(5), .NPC_W(64)) u_dut32 (
        .clock (clk),
        .reset (rst),
        .bus   (bus32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic hi,
                                   input logic [4:0] d, input logic [63:0] pc);
        logic [127:0] full;
        exp_t e;
        full   = {64'd0, a} * {64'd0, b};
        e.prod = hi ? full[127:64] : full[63:0];
        e.dest = d;
        e.npc  = pc;
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop and compare when a result leaves.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (bus.valid_out && !bus.stall) begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        n_out++;
                        chk("sb_product", bus.product, e.prod);
                        chk("sb_dest", 64'(bus.dest_reg_out), 64'(e.dest));
                        chk("sb_npc", bus.npc_out, e.npc);
                    end
                end
                if (bus.valid_in && bus.ready_out)
                    sb.push_back(model(bus.mplier, bus.mcand, bus.hi_sel, bus.dest_reg_in, bus.npc_in));
            end
        end
    end

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic hi,
                         input logic [4:0] d, input logic [63:0] pc);
        bus.valid_in    = 1'b1;
        bus.mplier      = a;
        bus.mcand       = b;
        bus.hi_sel      = hi;
        bus.dest_reg_in = d;
        bus.npc_in      = pc;
    endtask

    // Offer one operation (entered at a negedge) until accepted; optional random stall.
    task automatic offer(input logic [63:0] a, input logic [63:0] b, input logic hi,
                         input logic [4:0] d, input logic [63:0] pc, input bit rnd_stall);
        bit acc;
        acc = 1'b0;
        drive(a, b, hi, d, pc);
        for (int t = 0; t < 40 && !acc; t++) begin
            if (rnd_stall) bus.stall = ($urandom_range(0, 3) == 0);
            #2;
            acc = bus.ready_out;
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        chk("offer_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 60 && sb.size() != 0; t++) begin
            @(negedge clk);
            #2;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int   base;
        exp_t e0;
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.mplier = '0; bus.mcand = '0; bus.hi_sel = 1'b0;
        bus.dest_reg_in = '0; bus.npc_in = '0; bus.flush = 1'b0; bus.stall = 1'b0;
        bus32.valid_in = 1'b0; bus32.mplier = '0; bus32.mcand = '0; bus32.hi_sel = 1'b0;
        bus32.dest_reg_in = '0; bus32.npc_in = '0; bus32.flush = 1'b0; bus32.stall = 1'b0;

        // Reset state
        @(negedge clk); #2;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_product", bus.product, 64'd0);
        chk("rst_dest", 64'(bus.dest_reg_out), 64'd0);
        chk("rst_npc", bus.npc_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.ready_out), 64'd1);

        // 3*5, latency exactly 4
        @(negedge clk);
        drive(64'd3, 64'd5, 1'b0, 5'd7, 64'h100);
        #2;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.valid_in = 1'b0;
            #2;
            chk($sformatf("lat_valid_c%0d", i), 64'(bus.valid_out), 64'(i == 4));
            if (i == 4) begin
                chk("mul3x5_product", bus.product, 64'd15);
                chk("mul3x5_dest", 64'(bus.dest_reg_out), 64'd7);
            end
        end

        // MULQ then UMULH of all-ones*2 on consecutive cycles
        @(negedge clk);
        drive('1, 64'd2, 1'b0, 5'd1, 64'h200);
        #2;
        @(negedge clk);
        drive('1, 64'd2, 1'b1, 5'd2, 64'h204);
        #2;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            #2;
            chk($sformatf("lohi_valid_c%0d", i), 64'(bus.valid_out), 64'(i >= 4));
            if (i == 4) chk("mulq_allones", bus.product, 64'hFFFF_FFFF_FFFF_FFFE);
            if (i == 5) chk("umulh_allones", bus.product, 64'h1);
        end
        drain("drain_lohi");

        // Six back-to-back ops, stall 3 cycles after the first result
        base = n_out;
        e0 = model(64'd1007, 64'd3, 1'b0, 5'd10, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(64'(1007 + 1000 * k), 64'(3 + k), 1'b0, 5'(10 + k), 64'(4 * k));
            #2;
            chk($sformatf("b2b_ready_%0d", k), 64'(bus.ready_out), 64'd1);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            drive(64'd5007, 64'd7, 1'b0, 5'd14, 64'd16);
            bus.stall = 1'b1;
            #2;
            chk($sformatf("stall_valid_%0d", s), 64'(bus.valid_out), 64'd1);
            chk($sformatf("stall_ready_%0d", s), 64'(bus.ready_out), 64'd0);
            chk($sformatf("stall_hold_%0d", s), bus.product, e0.prod);
            chk($sformatf("stall_dest_%0d", s), 64'(bus.dest_reg_out), 64'd10);
        end
        @(negedge clk);
        bus.stall = 1'b0;
        #2;
        chk("unstall_ready", 64'(bus.ready_out), 64'd1);
        @(negedge clk);
        drive(64'd6007, 64'd8, 1'b0, 5'd15, 64'd20);
        #2;
        chk("b2b_ready_5", 64'(bus.ready_out), 64'd1);
        @(negedge clk);
        bus.valid_in = 1'b0;
        drain("drain_b2b");
        chk("b2b_count", 64'(n_out - base), 64'd6);

        // Random operands under random stall
        for (int j = 0; j < 12; j++) begin
            offer((j % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 64'(j * 4 + 64'h1000), 1'b1);
        end
        bus.stall = 1'b0;
        drain("drain_rand");

        // Flush with an operation offered in the flush cycle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(64'(11 + k), 64'(13 + k), 1'b0, 5'(20 + k), 64'h300);
            #2;
        end
        @(negedge clk);
        drive(64'd99, 64'd99, 1'b0, 5'd30, 64'h310);
        bus.flush = 1'b1;
        #2;
        chk("flush_ready_low", 64'(bus.ready_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.flush = 1'b0;
            bus.valid_in = 1'b0;
            #2;
            if (i == 0) chk("flush_ready_after", 64'(bus.ready_out), 64'd1);
            chk($sformatf("flush_no_valid_%0d", i), 64'(bus.valid_out), 64'd0);
        end

        // Asynchronous reset with two operations in flight
        @(negedge clk);
        drive(64'd1234, 64'd5678, 1'b0, 5'd3, 64'h400);
        #2;
        @(negedge clk);
        drive(64'd4321, 64'd8765, 1'b1, 5'd4, 64'h404);
        #2;
        @(negedge clk);
        bus.valid_in = 1'b0;
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("arst_product", bus.product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ready", 64'(bus.ready_out), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            chk($sformatf("arst_no_stale_%0d", i), 64'(bus.valid_out), 64'd0);
        end

        // 32-bit, 2-stage instance
        @(negedge clk);
        bus32.valid_in = 1'b1; bus32.mplier = 32'hFFFF_FFFF; bus32.mcand = 32'hFFFF_FFFF;
        bus32.hi_sel = 1'b0; bus32.dest_reg_in = 5'd9; bus32.npc_in = 64'h500;
        #2;
        chk("w32_ready", 64'(bus32.ready_out), 64'd1);
        @(negedge clk);
        bus32.hi_sel = 1'b1;
        #2;
        chk("w32_valid_c1", 64'(bus32.valid_out), 64'd0);
        @(negedge clk);
        bus32.valid_in = 1'b0;
        #2;
        chk("w32_valid_c2", 64'(bus32.valid_out), 64'd1);
        chk("w32_low", 64'(bus32.product), 64'h0000_0001);
        @(negedge clk); #2;
        chk("w32_valid_c3", 64'(bus32.valid_out), 64'd1);
        chk("w32_high", 64'(bus32.product), 64'hFFFF_FFFE);
        chk("w32_dest", 64'(bus32.dest_reg_out), 64'd9);

        @(negedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
